// File: rtl/tag_rx_hop_accum.sv
// rtl/tag_rx_hop_accum.sv - per-hop I/Q averager feeding a first-word-fall-through result FIFO
// Optional mean-power field: define TAG_RX_HOP_ACCUM_PWR_EN to add out_pwr.
module tag_rx_hop_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_AVG   = 13,
    parameter int NUM_HOPS   = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       irx_in,
    input  logic [DATA_WIDTH-1:0]       qrx_in,
    input  logic                        in_valid,
    input  logic [1:0]                  rx_state,
    output logic                        out_tvalid,
    input  logic                        out_tready,
    output logic [DATA_WIDTH-1:0]       out_i,
    output logic [DATA_WIDTH-1:0]       out_q,
    output logic [$clog2(NUM_HOPS)-1:0] out_hop,
    output logic                        out_last,
    output logic                        overflow,
`ifdef TAG_RX_HOP_ACCUM_PWR_EN
    output logic [2*DATA_WIDTH-1:0]     out_pwr,
`endif
    output logic [7:0]                  abort_count
);
    localparam int HW = $clog2(NUM_HOPS);
    localparam int AW = DATA_WIDTH + LOG2_AVG;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] RX_INIT = 2'b00;
    localparam logic [1:0] RX_LOC  = 2'b01;
    localparam logic [1:0] RX_HOP  = 2'b11;

    logic [1:0]          state;
    logic [1:0]          prev_state;
    logic [AW-1:0]       acc_i;
    logic [AW-1:0]       acc_q;
    logic [LOG2_AVG-1:0] cnt;
    logic [HW-1:0]       hop_idx;
    logic [HW-1:0]       hop_next;
    logic [HW-1:0]       push_hop;
    logic                push;
    logic                accept;
    logic                complete;
    logic                entry;
    logic                abort;
    logic                sweep;
    logic [AW-1:0]       ext_i;
    logic [AW-1:0]       ext_q;

    assign ext_i    = {{LOG2_AVG{irx_in[DATA_WIDTH-1]}}, irx_in};
    assign ext_q    = {{LOG2_AVG{qrx_in[DATA_WIDTH-1]}}, qrx_in};
    assign accept   = (state == S_ACCUM) && in_valid && (rx_state == RX_HOP);
    assign complete = accept && (cnt == {LOG2_AVG{1'b1}});
    assign entry    = (state == S_IDLE) && (rx_state == RX_HOP) && (prev_state != RX_HOP);
    assign abort    = (state == S_ACCUM) && (rx_state != RX_HOP);
    assign sweep    = (prev_state == RX_INIT) && (rx_state == RX_LOC);
    assign hop_next = (hop_idx == HW'(NUM_HOPS - 1)) ? '0 : hop_idx + HW'(1);

    // The result is written one edge after the final sample, from the settled accumulators.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            prev_state  <= RX_INIT;
            acc_i       <= '0;
            acc_q       <= '0;
            cnt         <= '0;
            hop_idx     <= '0;
            push        <= 1'b0;
            push_hop    <= '0;
            abort_count <= '0;
        end else begin
            prev_state <= rx_state;
            push       <= complete;
            if (complete) begin
                push_hop <= hop_idx;
            end
            if (entry) begin
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
            end else if (accept) begin
                acc_i <= acc_i + ext_i;
                acc_q <= acc_q + ext_q;
                cnt   <= cnt + LOG2_AVG'(1);
            end
            if (abort && (abort_count != 8'hff)) begin
                abort_count <= abort_count + 8'd1;
            end
            if (sweep) begin
                hop_idx <= '0;
            end else if (complete || abort) begin
                hop_idx <= hop_next;
            end
            case (state)
                S_IDLE:  if (entry) state <= S_ACCUM;
                S_ACCUM: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (complete) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  if (rx_state != RX_HOP) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] mem_i   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_q   [FIFO_DEPTH];
    logic [HW-1:0]         mem_hop [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  pop;
    logic                  wr_en;

    assign full       = (count == CW'(FIFO_DEPTH));
    assign out_tvalid = (count != '0);
    assign pop        = out_tvalid && out_tready;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign wr_en      = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_i[wr_ptr]   <= acc_i[AW-1:LOG2_AVG];
            mem_q[wr_ptr]   <= acc_q[AW-1:LOG2_AVG];
            mem_hop[wr_ptr] <= push_hop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_i    = out_tvalid ? mem_i[rd_ptr]   : '0;
    assign out_q    = out_tvalid ? mem_q[rd_ptr]   : '0;
    assign out_hop  = out_tvalid ? mem_hop[rd_ptr] : '0;
    assign out_last = (out_hop == HW'(NUM_HOPS - 1));

`ifdef TAG_RX_HOP_ACCUM_PWR_EN
    localparam int QW = 2 * DATA_WIDTH;

    logic signed [QW-1:0]    wide_i;
    logic signed [QW-1:0]    wide_q;
    logic [QW-1:0]           sq_i;
    logic [QW-1:0]           sq_q;
    logic [QW+LOG2_AVG-1:0]  acc_pwr;
    logic [QW-1:0]           mem_pwr [FIFO_DEPTH];

    assign wide_i = {{DATA_WIDTH{irx_in[DATA_WIDTH-1]}}, irx_in};
    assign wide_q = {{DATA_WIDTH{qrx_in[DATA_WIDTH-1]}}, qrx_in};
    assign sq_i   = wide_i * wide_i;
    assign sq_q   = wide_q * wide_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_pwr <= '0;
        end else if (entry) begin
            acc_pwr <= '0;
        end else if (accept) begin
            acc_pwr <= acc_pwr + {{LOG2_AVG{1'b0}}, sq_i} + {{LOG2_AVG{1'b0}}, sq_q};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pwr[wr_ptr] <= acc_pwr[QW+LOG2_AVG-1:LOG2_AVG];
        end
    end

    assign out_pwr = out_tvalid ? mem_pwr[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_tag_rx_hop_accum.sv
// tb/tb_tag_rx_hop_accum.sv - directed/randomised bench for tag_rx_hop_accum with a queue reference model
module tb_tag_rx_hop_accum;
    localparam int DW    = 16;
    localparam int L     = 4;
    localparam int AVG   = 1 << L;
    localparam int NH    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] irx_in;
    logic [DW-1:0] qrx_in;
    logic          in_valid;
    logic [1:0]    rx_state;
    logic          out_tvalid;
    logic          out_tready;
    logic [DW-1:0] out_i;
    logic [DW-1:0] out_q;
    logic [5:0]    out_hop;
    logic          out_last;
    logic          overflow;
    logic [7:0]    abort_count;
`ifdef TAG_RX_HOP_ACCUM_PWR_EN
    logic [2*DW-1:0] out_pwr;
`endif

    tag_rx_hop_accum #(
        .DATA_WIDTH (DW),
        .LOG2_AVG   (L),
        .NUM_HOPS   (NH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irx_in      (irx_in),
        .qrx_in      (qrx_in),
        .in_valid    (in_valid),
        .rx_state    (rx_state),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .out_i       (out_i),
        .out_q       (out_q),
        .out_hop     (out_hop),
        .out_last    (out_last),
        .overflow    (overflow),
`ifdef TAG_RX_HOP_ACCUM_PWR_EN
        .out_pwr     (out_pwr),
`endif
        .abort_count (abort_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [5:0]  hop;
    } ent_t;

    ent_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   exp_hop   = 0;
    int   exp_abort = 0;
    bit   exp_ovf   = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] floor_mean(input longint s);
        longint m;
        m = (s >= 0) ? s / AVG : -((-s + AVG - 1) / AVG);
        return m[15:0];
    endfunction

    task automatic sweep();
        rx_state = 2'b00; step();
        rx_state = 2'b01; step();
        exp_hop = 0;
    endtask

    task automatic pop_check(input string tag);
        ent_t e;
        e = exp_q.pop_front();
        check({tag, "_tvalid"}, out_tvalid, 1);
        check({tag, "_i"}, out_i, e.i);
        check({tag, "_q"}, out_q, e.q);
        check({tag, "_hop"}, out_hop, e.hop);
        check({tag, "_last"}, out_last, (e.hop == 6'd63));
        out_tready = 1'b1; step(); out_tready = 1'b0;
    endtask

    // n < AVG aborts the hop; mode 0 random with gaps, 1 constant, 2 alternating -1/0
    task automatic do_hop(input int n, input int mode, input bit pop_with_push);
        longint      si;
        longint      sq;
        int          k;
        int          iv;
        int          qv;
        logic [15:0] r;
        ent_t        e;
        ent_t        h;
        si = 0; sq = 0; k = 0;
        rx_state = 2'b10; in_valid = 1'b0; step();
        rx_state = 2'b11; in_valid = 1'b1; irx_in = 16'h7fff; qrx_in = 16'h8000; step();
        while (k < n) begin
            if (mode == 0 && $urandom_range(3) == 0) begin
                in_valid = 1'b0; irx_in = 16'($urandom); qrx_in = 16'($urandom);
            end else begin
                case (mode)
                    1: begin iv = 1000; qv = -500; end
                    2: begin iv = (k % 2 == 0) ? -1 : 0; qv = 0; end
                    default: begin
                        r = 16'($urandom); iv = $signed(r);
                        r = 16'($urandom); qv = $signed(r);
                    end
                endcase
                in_valid = 1'b1; irx_in = 16'(iv); qrx_in = 16'(qv);
                si += iv; sq += qv; k++;
            end
            step();
        end
        in_valid = 1'b0;
        if (n < AVG) begin
            rx_state = 2'b10; step();
            exp_abort = (exp_abort < 255) ? exp_abort + 1 : 255;
        end else begin
            e.i = floor_mean(si); e.q = floor_mean(sq); e.hop = 6'(exp_hop);
            if (pop_with_push) begin
                h = exp_q.pop_front();
                check("pp_head_i", out_i, h.i);
                check("pp_head_hop", out_hop, h.hop);
                exp_q.push_back(e);
                out_tready = 1'b1; step(); out_tready = 1'b0;
            end else if (exp_q.size() < DEPTH) begin
                exp_q.push_back(e);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        exp_hop = (exp_hop + 1) % NH;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; irx_in = '0; qrx_in = '0;
        rx_state = 2'b00; out_tready = 1'b0;
        #12;
        check("rst_tvalid", out_tvalid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_abort", abort_count, 0);
        check("rst_i", out_i, 0);
        check("rst_q", out_q, 0);
        check("rst_hop", out_hop, 0);
        check("rst_last", out_last, 0);
        step(); reset = 1'b0; step();

        // constant input: tvalid must rise exactly one edge after the final sample
        sweep();
        do_hop(AVG, 1, 1'b0);
        check("a_tvalid_early", out_tvalid, 0);
        step();
        check("a_tvalid", out_tvalid, 1);
        check("a_i", out_i, 16'd1000);
        check("a_q", out_q, 16'hFE0C);
`ifdef TAG_RX_HOP_ACCUM_PWR_EN
        check("a_pwr", out_pwr, 32'd1250000);
`endif
        pop_check("a");
        check("a_drained", out_tvalid, 0);

        // alternating -1/0 exercises floor on the arithmetic shift
        do_hop(AVG, 2, 1'b0); step();
        check("b_floor", out_i, 16'hFFFF);
        pop_check("b");

        for (int h = 0; h < 3; h++) do_hop(AVG, 0, 1'b0);
        step();
        for (int h = 0; h < 3; h++) pop_check("c");

        // abort after a partial window
        sweep();
        do_hop(10, 0, 1'b0);
        check("d_no_entry", out_tvalid, 0);
        check("d_abort", abort_count, exp_abort);
        do_hop(AVG, 0, 1'b0); step();
        check("d_next_hop", out_hop, 1);
        pop_check("d_next");

        // overflow, then push coinciding with pop while full
        for (int h = 0; h < 4; h++) do_hop(AVG, 0, 1'b0);
        step();
        check("e_no_ovf_yet", overflow, exp_ovf);
        do_hop(AVG, 0, 1'b0); step();
        check("e_overflow", overflow, exp_ovf);
        do_hop(AVG, 0, 1'b1);
        for (int h = 0; h < 4; h++) pop_check("e_drain");
        check("e_empty", out_tvalid, 0);
        check("e_ovf_sticky", overflow, exp_ovf);

        // full sweep, then restart at hop 0
        sweep();
        for (int h = 0; h < NH; h++) begin
            do_hop(AVG, 0, 1'b0); step();
            pop_check("f");
        end
        sweep();
        do_hop(AVG, 0, 1'b0); step();
        check("f_restart_hop", out_hop, 0);
        pop_check("f_restart");

        // asynchronous reset mid-hop with two entries held
        for (int h = 0; h < 2; h++) do_hop(AVG, 0, 1'b0);
        rx_state = 2'b10; step();
        rx_state = 2'b11; in_valid = 1'b1; irx_in = 16'h4000; qrx_in = 16'h4000;
        repeat (5) step();
        check("g_two_held", out_tvalid, 1);
        #3 reset = 1'b1; rx_state = 2'b10; in_valid = 1'b0;
        #1;
        check("g_tvalid_async", out_tvalid, 0);
        check("g_ovf_async", overflow, 0);
        check("g_abort_async", abort_count, 0);
        check("g_i_async", out_i, 0);
        check("g_hop_async", out_hop, 0);
        step(); reset = 1'b0;
        exp_q.delete(); exp_hop = 0; exp_abort = 0; exp_ovf = 1'b0;
        do_hop(AVG, 0, 1'b0); step();
        pop_check("g");
        check("g_abort_after", abort_count, exp_abort);
        check("g_empty", out_tvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
